queue_reader: RTL and testbench
===============================

QUEUE_READER -- requirements
Module: queue_reader

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 q_empty  input  1  empty flag from the upstream queue.
REQ-005 q_data  input  WIDTH  upstream queue read data, valid the cycle after q_rd is sampled high.
REQ-006 q_rd  output  1  read strobe to the upstream queue.
REQ-007 out_data  output  WIDTH  head word of the internal buffer.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-010 Block SHALL drain the upstream queue into a 3-entry internal buffer and present words in strict FIFO order on a valid/ready stream.
REQ-011 Transfer (pop) SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-012 In-flight flag inflight SHALL be set on an edge where q_rd=1, else cleared.
REQ-013 q_rd SHALL be a function of registers and q_empty only: q_rd = !q_empty && (occ + inflight < 3), where occ is buffer occupancy 0..3.
REQ-014 q_rd SHALL never assert while q_empty=1; no combinational path from out_ready to q_rd.
REQ-015 On an edge with inflight=1, q_data SHALL be written at the buffer tail.
REQ-016 Occupancy states EMPTY, ONE, TWO, THREE: capture only -> +1; pop only -> -1; capture and pop same edge -> unchanged; neither -> unchanged.
REQ-017 Capture into a full buffer SHALL be impossible by construction; bench SHALL flag it as an error.
REQ-018 out_valid SHALL equal (occ != 0), registered; out_data SHALL be the head entry and hold stable while out_valid=1 and out_ready=0.
REQ-019 Latency: q_empty falls at cycle 0 with block empty -> q_rd=1 cycle 0, capture at edge ending cycle 1, out_valid=1 in cycle 2.
REQ-020 Throughput: with q_empty=0 and out_ready=1 held, SHALL sustain one word per cycle after fill.
REQ-021 Buffer pointers SHALL be 2-bit and wrap 2 -> 0.
REQ-022 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-023 reset=0 SHALL asynchronously clear occ, pointers and inflight; q_rd=0, out_valid=0, out_data=0.
REQ-024 Reset mid-operation SHALL discard buffered and in-flight words; upstream queue is reset simultaneously.
REQ-025 First q_rd after release SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-026 Macro QUEUE_READER_COUNT_EN defined: SHALL add output word_count [15:0], reset to 0, +1 on each pop, wrap 0xFFFF -> 0x0000.
REQ-027 Macro undefined: word_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Fill: queue holds 5,6,7, out_ready=0 -> q_rd high 3 cycles then 0; out_valid=1, out_data=5 stable; occ=THREE.
REQ-029 Stream: 20 words 0..19 queued, out_ready=1 -> out_data 0..19 in order, one per cycle from cycle 2, no gaps.
REQ-030 Backpressure: out_ready toggles 1,0,1,0 over words 0xA0..0xAF -> all 16 delivered once, in order, none lost or duplicated.
REQ-031 Empty boundary: one word 0x3C queued, then q_empty=1 -> exactly one q_rd pulse, one transfer of 0x3C, out_valid returns 0.
REQ-032 Reset mid-stream: reset=0 with occ=TWO, inflight=1 -> out_valid=0, q_rd=0 immediately, independent of clk.
REQ-033 With QUEUE_READER_COUNT_EN: 65537 transfers -> word_count=0x0001.

Source files
------------

// File: rtl/queue_reader.sv
// queue_reader: drains an upstream queue with one-cycle read latency into a
// 3-entry buffer and presents the words in FIFO order on a valid/ready stream.
// Optional feature: define QUEUE_READER_COUNT_EN to add the 16-bit word_count
// output, which counts delivered words and wraps 0xFFFF -> 0x0000.
module queue_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_empty,
  input  logic [WIDTH-1:0] q_data,
  output logic             q_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef QUEUE_READER_COUNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2,
    OCC_THREE = 2'd3
  } occ_e;

  occ_e             r_occ;
  logic             r_out_valid;
  logic             r_inflight;
  logic             r_run;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [WIDTH-1:0] r_buf [3];

  logic             w_room;
  logic             w_capture;
  logic             w_pop;

  // Pointers step through 0,1,2 and wrap back to 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A word is captured on the edge after a read strobe; a pop needs valid and ready.
  assign w_capture = r_inflight;
  assign w_pop     = r_out_valid && out_ready;

  // Free slots must cover buffered words plus the one already requested.
  always_comb begin
    // NOTE: default first so every path assigns w_room and no latch is inferred.
    w_room = 1'b0;
    unique case (r_occ)
      OCC_EMPTY: w_room = 1'b1;
      OCC_ONE:   w_room = 1'b1;
      OCC_TWO:   w_room = !r_inflight;
      OCC_THREE: w_room = 1'b0;
    endcase
  end

  // r_run holds the strobe off until the first edge after reset release.
  assign q_rd      = r_run && !q_empty && w_room;
  assign out_valid = r_out_valid;
  assign out_data  = r_buf[r_rd_ptr];

  // Occupancy FSM with registered valid flag, plus the in-flight and run flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_occ       <= OCC_EMPTY;
      r_out_valid <= 1'b0;
      r_inflight  <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= q_rd;
      unique case (r_occ)
        OCC_EMPTY: begin
          if (w_capture) begin
            r_occ       <= OCC_ONE;
            r_out_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_capture && !w_pop) begin
            r_occ <= OCC_TWO;
          end else if (w_pop && !w_capture) begin
            r_occ       <= OCC_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (w_capture && !w_pop) begin
            r_occ <= OCC_THREE;
          end else if (w_pop && !w_capture) begin
            r_occ <= OCC_ONE;
          end
        end
        OCC_THREE: begin
          // The read-strobe rule leaves no request outstanding when full.
          if (w_pop) begin
            r_occ <= OCC_TWO;
          end
        end
      endcase
    end
  end

  // Buffer storage and tail pointer: captured word goes to the tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the 3-entry buffer is reset so out_data reads zero during and after reset.
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= 2'd0;
    end else if (w_capture) begin
      r_buf[r_wr_ptr] <= q_data;
      r_wr_ptr        <= ptr_inc(r_wr_ptr);
    end
  end

  // Head pointer advances on every accepted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= 2'd0;
    end else if (w_pop) begin
      r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

`ifdef QUEUE_READER_COUNT_EN
  logic [15:0] r_word_count;

  // Delivered-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_count <= 16'd0;
    end else if (w_pop) begin
      r_word_count <= r_word_count + 16'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_queue_reader.sv
// tb_queue_reader: randomized and directed stimulus against a count-based
// reference model; words expected downstream are queued when offered upstream
// and a negedge monitor pops and compares each delivered word.
module tb_queue_reader;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             q_empty = 1'b1;
  logic [WIDTH-1:0] q_data = '0;
  logic             q_rd;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef QUEUE_READER_COUNT_EN
  logic [15:0]      word_count;
`endif

  queue_reader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .q_rd      (q_rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef QUEUE_READER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Upstream queue contents and scoreboard of words owed downstream.
  logic [WIDTH-1:0] upq[$];
  logic [WIDTH-1:0] exp_q[$];

  int cycle = 0;
  int xfer_cycles[$];
  int n_xfer = 0;
  int n_rd = 0;
  int xfer_since_reset = 0;

  // Reference model: buffered words = words fetched (landing one edge after
  // the strobe) minus words delivered; capacity is three.
  int occ_m = 0;
  bit infl_m = 1'b0;
  bit rd_pending = 1'b0;
  bit xfer_pending = 1'b0;
  bit prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares delivered words with the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_q_rd", 32'(q_rd), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      rd_pending   = 1'b0;
      xfer_pending = 1'b0;
      prev_hold    = 1'b0;
    end else begin
      check("valid_vs_model", 32'(out_valid), 32'(occ_m != 0));
      if (q_empty) check("rd_while_empty", 32'(q_rd), 32'd0);
      if (prev_hold && out_valid) check("hold_stable", 32'(out_data), 32'(prev_data));
      rd_pending = q_rd;
      if (q_rd) n_rd++;
      xfer_pending = out_valid && out_ready;
      if (xfer_pending) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          check("data_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
        n_xfer++;
        xfer_since_reset++;
        xfer_cycles.push_back(cycle);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // Upstream queue behaviour and model update, shortly after each edge.
  always @(posedge clk) begin
    cycle++;
    #1;
    if (reset) begin
      if (infl_m) check("capture_not_full", 32'(occ_m < 3), 32'd1);
      occ_m  = occ_m + int'(infl_m) - int'(xfer_pending);
      infl_m = rd_pending;
      if (rd_pending) begin
        if (upq.size() > 0) begin
          q_data = upq.pop_front();
        end else begin
          checks++;
          errors++;
          $display("FAIL read_underflow: got strobe expected none");
        end
      end else begin
        q_data = WIDTH'($urandom);
      end
      q_empty = (upq.size() == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    upq.push_back(w);
    exp_q.push_back(w);
    q_empty = 1'b0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    upq.delete();
    exp_q.delete();
    occ_m            = 0;
    infl_m           = 1'b0;
    rd_pending       = 1'b0;
    xfer_pending     = 1'b0;
    q_empty          = 1'b1;
    xfer_since_reset = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    out_ready = 1'b1;
    for (k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && upq.size() == 0 && !out_valid && !q_rd) break;
      tick();
    end
    check(name, 32'(k < budget), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    int base_rd;
    int base_x;
    int gaps;
    int pushed;

    assert_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_q_rd_direct", 32'(q_rd), 32'd0);
    check("reset_valid_direct", 32'(out_valid), 32'd0);
    reset = 1'b1;
    tick();

    // Fill with backpressure: three strobes, head word 5 held.
    out_ready = 1'b0;
    base_rd = n_rd;
    push(8'd5);
    push(8'd6);
    push(8'd7);
    repeat (8) tick();
    check("fill_rd_pulses", 32'(n_rd - base_rd), 32'd3);
    check("fill_valid", 32'(out_valid), 32'd1);
    check("fill_head", 32'(out_data), 32'd5);
    check("fill_q_rd_idle", 32'(q_rd), 32'd0);
    drain("fill_drain", 100);

    // Stream of 20 words: strobe in cycle 0, first word in cycle 2, no gaps.
    out_ready = 1'b1;
    xfer_cycles.delete();
    start = cycle;
    for (int i = 0; i < 20; i++) push(WIDTH'(i));
    #1;
    check("latency_q_rd_cycle0", 32'(q_rd), 32'd1);
    drain("stream_drain", 200);
    check("stream_count", 32'(xfer_cycles.size()), 32'd20);
    if (xfer_cycles.size() > 0) begin
      check("stream_first_cycle", 32'(xfer_cycles[0] - start), 32'd2);
      gaps = 0;
      for (int i = 1; i < xfer_cycles.size(); i++) begin
        if (xfer_cycles[i] - xfer_cycles[i-1] != 1) gaps++;
      end
      check("stream_gaps", 32'(gaps), 32'd0);
    end

    // Backpressure: ready toggles every cycle over 0xA0..0xAF.
    base_x = n_xfer;
    for (int i = 0; i < 16; i++) push(WIDTH'(8'hA0 + i));
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && upq.size() == 0 && !out_valid) break;
      out_ready = (k % 2 == 0);
      tick();
    end
    check("bp_delivered", 32'(n_xfer - base_x), 32'd16);
    check("bp_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Empty boundary: a single word then the queue runs dry.
    out_ready = 1'b1;
    tick();
    base_rd = n_rd;
    base_x  = n_xfer;
    push(8'h3C);
    repeat (10) tick();
    check("single_rd_pulses", 32'(n_rd - base_rd), 32'd1);
    check("single_xfers", 32'(n_xfer - base_x), 32'd1);
    check("single_valid_low", 32'(out_valid), 32'd0);

    // Randomized traffic and backpressure.
    base_x = n_xfer;
    pushed = 0;
    for (int k = 0; k < 400; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          push(WIDTH'($urandom));
          pushed++;
        end
      end
      tick();
    end
    drain("random_drain", 2000);
    check("random_delivered", 32'(n_xfer - base_x), 32'(pushed));

    // Reset mid-stream with two buffered words and one in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(WIDTH'(8'h40 + i));
    repeat (3) tick();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #1;
    assert_reset();
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_q_rd", 32'(q_rd), 32'd0);
    check("async_reset_data", 32'(out_data), 32'd0);
    repeat (3) tick();
    push(8'h55);
    reset = 1'b1;
    #1;
    check("no_rd_before_edge", 32'(q_rd), 32'd0);
    tick();
    check("rd_after_edge", 32'(q_rd), 32'd1);
    drain("post_reset_drain", 100);

`ifdef QUEUE_READER_COUNT_EN
    tick();
    assert_reset();
    tick();
    reset = 1'b1;
    tick();
    check("count_after_reset", 32'(word_count), 32'd0);
    for (int i = 0; i < 65537; i++) push(WIDTH'(i));
    drain("count_drain", 70000);
    check("count_wrap", 32'(word_count), 32'(16'(65537)));
`endif

    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
